// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that packs a byte stream into words and writes them into fetch-stage instruction memory
module imem_loader #(
  parameter int WORDS = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [15:0] len,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        if_rst,
  output logic        if_we,
  output logic [31:0] if_wins,
  output logic [1:0]  if_bout,
  output logic [31:0] if_newpc,
  output logic        core_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CLR  = 3'd1;
  localparam logic [2:0] FILL = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] FIN  = 3'd4;
  logic [2:0]  state;
  logic [15:0] cnt;
  logic [15:0] len_q;
  logic [1:0]  idx;
  logic [31:0] asm_q;
  logic        rst_q;
  logic        err_q;
  logic        len_ok;
  logic        take;
  assign len_ok = (len != 16'd0) && (len <= 16'(WORDS));
  assign take   = byte_valid & byte_ready;
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
      cnt   <= 16'd0;
      len_q <= 16'd0;
      idx   <= 2'd0;
      asm_q <= 32'd0;
      rst_q <= 1'b1;
      err_q <= 1'b0;
    end else begin
      rst_q <= 1'b0;
      err_q <= (state == IDLE) && start && !len_ok;
      case (state)
        IDLE: if (start && len_ok) begin
          len_q <= len;
          cnt   <= 16'd0;
          idx   <= 2'd0;
          state <= CLR;
        end
        CLR: state <= FILL;
        FILL: if (take) begin
          // first byte of a word lands in the most significant lane
          asm_q[{~idx, 3'b000} +: 8] <= byte_data;
          idx <= idx + 2'd1;
          if (idx == 2'd3) state <= WR;
        end
        WR: if (cnt == len_q - 16'd1) state <= FIN;
        else begin
          cnt   <= cnt + 16'd1;
          idx   <= 2'd0;
          state <= FILL;
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign byte_ready = state == FILL;
  assign if_rst     = rst_q | (state == CLR) | (state == FIN);
  assign if_we      = state == WR;
  assign if_wins    = asm_q;
  assign if_bout    = {1'b0, state == WR};
  assign if_newpc   = (state == WR) ? {14'd0, cnt + 16'd1, 2'b00} : 32'd0;
  assign busy       = state != IDLE;
  assign core_hold  = busy;
  assign done       = state == FIN;
  assign err        = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader with a behavioural fetch-stage model
module tb_imem_loader;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [15:0] len = 16'd0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready, if_rst, if_we, core_hold, busy, done, err;
  logic [31:0] if_wins, if_newpc;
  logic [1:0]  if_bout;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] imem [0:63];
  logic [31:0] pc = 32'd0;
  logic        wipe = 1'b0;
  logic [7:0]  stim [0:255];
  bit got_done, aborted, fin_ok;
  int bcyc, nwr, rdy_bad, bout_bad, npc_bad, k_acc;
  logic [31:0] last_wins, last_npc;

  imem_loader #(.WORDS(64)) dut (
    .CLK(CLK), .RST(RST), .start(start), .len(len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .if_rst(if_rst), .if_we(if_we), .if_wins(if_wins), .if_bout(if_bout),
    .if_newpc(if_newpc), .core_hold(core_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  // fetch stage: writes at the old PC and loads the new PC on the same edge
  always @(posedge CLK) begin
    if (wipe) begin
      for (int i = 0; i < 64; i++) imem[i] <= 32'hDEADBEEF;
    end else if (if_we) imem[pc[7:2]] <= if_wins;
    if (if_rst) pc <= 32'd0;
    else if (if_bout == 2'b01) pc <= if_newpc;
  end

  task automatic wipe_mem;
    wipe = 1'b1;
    @(negedge CLK);
    wipe = 1'b0;
    @(negedge CLK);
  endtask

  task automatic run_load(input int n, input bit gaps, input int abort_at);
    int k;
    k = 0; got_done = 0; aborted = 0; fin_ok = 0; bcyc = 0; nwr = 0;
    rdy_bad = 0; bout_bad = 0; npc_bad = 0; last_wins = 'x; last_npc = 'x;
    start = 1'b1; len = 16'(n);
    @(negedge CLK);
    start = 1'b0;
    for (int cyc = 0; cyc < 2000 && !got_done; cyc++) begin
      if (abort_at >= 0 && k == abort_at) begin
        aborted = 1;
        break;
      end
      if (busy) bcyc++;
      if (done) begin got_done = 1; if (if_rst) fin_ok = 1; end
      if (byte_ready && (if_rst || if_we)) rdy_bad++;
      if (!byte_ready && !if_rst && !if_we && busy) rdy_bad++;
      if (if_we) begin
        nwr++; last_wins = if_wins; last_npc = if_newpc;
        if (if_bout !== 2'b01) bout_bad++;
      end else begin
        if (if_bout !== 2'b00) bout_bad++;
        if (if_newpc !== 32'd0) npc_bad++;
      end
      byte_valid = (k < 4 * n) && (!gaps || $urandom_range(0, 2) != 0);
      byte_data = stim[k % 256];
      if (byte_valid && byte_ready) k++;
      @(negedge CLK);
    end
    byte_valid = 1'b0;
    k_acc = k;
  endtask

  task automatic test_reset;
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp++; if (if_rst !== 1'b1) begin n_bad++; $display("FAIL reset_if_rst got %b want 1", if_rst); end
    n_cmp++; if ({busy, if_we, byte_ready, done, err} !== 5'b0) begin n_bad++; $display("FAIL reset_outs got %b want 00000", {busy, if_we, byte_ready, done, err}); end
    n_cmp++; if (if_bout !== 2'b00) begin n_bad++; $display("FAIL reset_bout got %b want 00", if_bout); end
    RST = 1'b1;
    @(negedge CLK);
    n_cmp++; if ({if_rst, busy} !== 2'b00) begin n_bad++; $display("FAIL release_idle got %b want 00", {if_rst, busy}); end
    n_cmp++; if (pc !== 32'd0) begin n_bad++; $display("FAIL reset_pc got %h want 0", pc); end
  endtask

  task automatic test_single;
    wipe_mem();
    stim[0] = 8'h20; stim[1] = 8'h08; stim[2] = 8'h00; stim[3] = 8'h05;
    run_load(1, 0, -1);
    n_cmp++; if (!got_done) begin n_bad++; $display("FAIL single_timeout got no done want done"); end
    n_cmp++; if (bcyc != 7) begin n_bad++; $display("FAIL single_busy got %0d want 7", bcyc); end
    n_cmp++; if (nwr != 1) begin n_bad++; $display("FAIL single_nwr got %0d want 1", nwr); end
    n_cmp++; if (last_wins !== 32'h20080005) begin n_bad++; $display("FAIL single_wins got %h want 20080005", last_wins); end
    n_cmp++; if (last_npc !== 32'd4) begin n_bad++; $display("FAIL single_newpc got %h want 4", last_npc); end
    n_cmp++; if (!fin_ok) begin n_bad++; $display("FAIL single_fin got no done&if_rst want both"); end
    n_cmp++; if (bout_bad + npc_bad + rdy_bad != 0) begin n_bad++; $display("FAIL single_ctrl got %0d/%0d/%0d want 0/0/0", bout_bad, npc_bad, rdy_bad); end
    n_cmp++; if (imem[0] !== 32'h20080005) begin n_bad++; $display("FAIL single_imem0 got %h want 20080005", imem[0]); end
    n_cmp++; if ({busy, done, pc} !== {2'b00, 32'd0}) begin n_bad++; $display("FAIL single_after got busy=%b done=%b pc=%h want 0 0 0", busy, done, pc); end
  endtask

  task automatic test_full;
    logic [31:0] exp;
    wipe_mem();
    for (int k = 0; k < 256; k++) stim[k] = 8'(k);
    run_load(64, 0, -1);
    n_cmp++; if (bcyc != 322) begin n_bad++; $display("FAIL full_busy got %0d want 322", bcyc); end
    n_cmp++; if (last_npc !== 32'd256) begin n_bad++; $display("FAIL full_newpc got %0d want 256", last_npc); end
    n_cmp++; if (pc !== 32'd0) begin n_bad++; $display("FAIL full_pc got %h want 0", pc); end
    for (int k = 0; k < 64; k++) begin
      exp = {8'(4 * k), 8'(4 * k + 1), 8'(4 * k + 2), 8'(4 * k + 3)};
      n_cmp++; if (imem[k] !== exp) begin n_bad++; $display("FAIL full_imem[%0d] got %h want %h", k, imem[k], exp); end
    end
  endtask

  task automatic test_gaps;
    wipe_mem();
    for (int k = 0; k < 12; k++) stim[k] = 8'(8'h11 * (k + 1));
    run_load(3, 1, -1);
    n_cmp++; if (!got_done) begin n_bad++; $display("FAIL gaps_timeout got no done want done"); end
    n_cmp++; if (k_acc != 12) begin n_bad++; $display("FAIL gaps_bytes got %0d want 12", k_acc); end
    n_cmp++; if (rdy_bad != 0) begin n_bad++; $display("FAIL gaps_ready got %0d bad cycles want 0", rdy_bad); end
    n_cmp++; if (imem[0] !== 32'h11223344) begin n_bad++; $display("FAIL gaps_imem0 got %h want 11223344", imem[0]); end
    n_cmp++; if (imem[1] !== 32'h55667788) begin n_bad++; $display("FAIL gaps_imem1 got %h want 55667788", imem[1]); end
    n_cmp++; if (imem[2] !== 32'h99AABBCC) begin n_bad++; $display("FAIL gaps_imem2 got %h want 99aabbcc", imem[2]); end
    n_cmp++; if (imem[3] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL gaps_imem3 got %h want deadbeef", imem[3]); end
  endtask

  task automatic test_illegal;
    int bad_seen;
    for (int t = 0; t < 2; t++) begin
      start = 1'b1; len = (t == 0) ? 16'd0 : 16'd65;
      @(negedge CLK);
      start = 1'b0;
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL illegal%0d_err got %b want 1", t, err); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL illegal%0d_busy got %b want 0", t, busy); end
      @(negedge CLK);
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL illegal%0d_errpulse got %b want 0", t, err); end
      bad_seen = 0;
      repeat (3) begin
        if (if_we || busy) bad_seen++;
        @(negedge CLK);
      end
      n_cmp++; if (bad_seen != 0) begin n_bad++; $display("FAIL illegal%0d_idle got %0d active cycles want 0", t, bad_seen); end
    end
  endtask

  task automatic test_abort;
    wipe_mem();
    for (int k = 0; k < 16; k++) stim[k] = 8'(8'h40 + k);
    run_load(4, 0, 10);
    n_cmp++; if (!aborted) begin n_bad++; $display("FAIL abort_reach got %0d bytes want 10", k_acc); end
    RST = 1'b0;
    @(negedge CLK);
    n_cmp++; if ({if_rst, busy, if_we} !== 3'b100) begin n_bad++; $display("FAIL abort_reset got %b want 100", {if_rst, busy, if_we}); end
    RST = 1'b1;
    @(negedge CLK);
    n_cmp++; if ({if_rst, busy} !== 2'b00) begin n_bad++; $display("FAIL abort_release got %b want 00", {if_rst, busy}); end
    n_cmp++; if (imem[0] !== 32'h40414243) begin n_bad++; $display("FAIL abort_imem0 got %h want 40414243", imem[0]); end
    n_cmp++; if (imem[1] !== 32'h44454647) begin n_bad++; $display("FAIL abort_imem1 got %h want 44454647", imem[1]); end
    n_cmp++; if (imem[2] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL abort_imem2 got %h want deadbeef", imem[2]); end
    stim[0] = 8'hC0; stim[1] = 8'hFF; stim[2] = 8'hEE; stim[3] = 8'h01;
    run_load(1, 0, -1);
    n_cmp++; if (bcyc != 7) begin n_bad++; $display("FAIL reload_busy got %0d want 7", bcyc); end
    n_cmp++; if (imem[0] !== 32'hC0FFEE01) begin n_bad++; $display("FAIL reload_imem0 got %h want c0ffee01", imem[0]); end
    n_cmp++; if (imem[1] !== 32'h44454647) begin n_bad++; $display("FAIL reload_imem1 got %h want 44454647", imem[1]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_gaps();
    test_illegal();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory loader for the minimum MIPS core. Accepts a byte stream over a valid/ready handshake, packs bytes big-endian into 32-bit words and writes them into the fetch stage's instruction memory at consecutive word addresses. It does this by driving the fetch stage's write port and branch/PC inputs, holding the rest of the core idle while busy. When the load completes it returns PC to 0 and releases the core.

## Interface
- WORDS, 64: instruction memory depth in words; legal load lengths are 1..WORDS.
- CLK  in  1  clock; all state changes on posedge.
- RST  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request to begin a load; sampled only in IDLE.
- len  in  16  number of words to load; latched on accepted start.
- byte_valid  in  1  byte_data holds a valid byte.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle; transfer occurs when byte_valid & byte_ready.
- if_rst  out  1  drives the fetch stage reset (active-high; forces PC = 0).
- if_we  out  1  fetch-stage instruction-memory write enable.
- if_wins  out  32  word to write at the current PC.
- if_bout  out  2  fetch-stage PC-load select; 2'b01 loads if_newpc, 2'b00 holds PC.
- if_newpc  out  32  next PC value during writes.
- core_hold  out  1  stalls the rest of the pipeline; equals busy.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a load completes.
- err  out  1  one-cycle pulse when start is rejected.

## Operation
- States: IDLE, CLR, FILL, WR, FIN. Moore outputs decoded from the registered state.
- IDLE: byte_ready=0, if_we=0, if_bout=00, if_rst=0.
  - start with 1 ≤ len ≤ WORDS: latch len, clear word counter and byte index, go to CLR.
  - start with len=0 or len>WORDS: err=1 on the next cycle, stay IDLE.
- CLR: if_rst=1 for one cycle so PC=0, then go to FILL.
- FILL: byte_ready=1. Each accepted byte goes into lane 3-idx (first byte → bits 31:24). idx increments 0..3. After the 4th byte is accepted, go to WR.
- WR (one cycle):
  - if_we=1, if_wins=assembled word, if_bout=2'b01, if_newpc=4·(cnt+1) (32-bit, zero-extended).
  - The fetch stage writes IMem[PC>>2] using the old PC and loads the new PC on the same edge.
  - cnt==len-1: go to FIN. Otherwise cnt++, idx=0, go to FILL.
- FIN: if_rst=1 for one cycle (PC back to 0) and done=1, then go to IDLE.
- start while busy is ignored. byte_valid outside FILL is not consumed.
- if_wins holds the assembly register in every state. if_newpc is 0 outside WR.

## Timing
- Reset (RST=0 at an edge): state=IDLE, cnt=0, idx=0, assembly register=0. After that edge and until the first edge with RST=1: if_rst=1, busy=0, done=0, err=0, if_we=0, if_bout=00, byte_ready=0. From the first IDLE cycle after reset release: if_rst=0.
- Start sampled at edge N: CLR during cycle N+1; FILL from N+2.
- With byte_valid held high: 4 FILL cycles + 1 WR cycle per word. A len-word load takes 5·len + 2 cycles from start to the end of done, including CLR and FIN.
- Stalled stream (byte_valid=0): FILL waits indefinitely; no timeout.
- Reset mid-load: returns to IDLE at the next edge. The partial word is discarded; words already written remain in IMem. if_rst is high while RST is low, so the core never runs on a half-loaded PC.
- Boundary: len=WORDS writes the last word at address 4·(WORDS-1) and sets if_newpc=4·WORDS. Because FIN immediately resets PC, no out-of-range fetch occurs.

## Test plan
- Reset: hold RST=0 for 3 cycles → if_rst=1, busy=0, if_we=0, byte_ready=0; release → IDLE with if_rst=0.
- Single word: len=1, bytes 8'h20,8'h08,8'h00,8'h05 back-to-back → one WR cycle with if_wins=32'h20080005, if_bout=01, if_newpc=4. Then FIN with if_rst=1 and done=1; busy high for exactly 7 cycles.
- Full image: len=64 with an incrementing-byte stream → IMem[k] = {4k,4k+1,4k+2,4k+3} mod 256 for k=0..63. Last if_newpc=256; PC=0 after done.
- Backpressure/gaps: drop byte_valid randomly during a len=3 load → identical IMem contents, no byte lost or duplicated; byte_ready=0 during CLR, WR and FIN.
- Illegal start: len=0, then len=65 → each gives err pulse one cycle later; busy stays 0; no if_we.
- Abort: RST=0 after 2 bytes of word 2 in a len=4 load → words 0–1 written, word 2 absent, IDLE after release. A new start with len=1 then loads correctly.
